// File: rtl/brick_board.sv
// brick_board: 12x16 brick occupancy grid for the VGA display stage.
// The game logic edits a working copy of the grid through a valid/ready
// command port. The working copy is published to `data` only at frame
// boundaries, so the display never shows a half-applied edit.
// Ports:
//   clock, reset        system clock, synchronous active-low reset
//   cmd_valid/cmd_ready command handshake (cmd_ready = !busy)
//   cmd_op/row/col      command opcode and target cell/row
//   frame_start         one-cycle pulse at the start of vertical sync
//   data                committed grid, bit index = row*COLS + col
//   rd_row/rd_col       working-grid read address
//   rd_bit              registered working-grid read data
//   row_full            combinational, one bit per full working row
//   busy                a multi-cycle sweep is in progress
//   err                 sticky out-of-range command flag
module brick_board #(
  parameter int unsigned ROWS = 12,
  parameter int unsigned COLS = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [3:0]           cmd_row,
  input  logic [3:0]           cmd_col,
  input  logic                 frame_start,
  output logic [ROWS*COLS-1:0] data,
  input  logic [3:0]           rd_row,
  input  logic [3:0]           rd_col,
  output logic                 rd_bit,
  output logic [ROWS-1:0]      row_full,
  output logic                 busy,
  output logic                 err
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned CMP_W = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    CLR_SWEEP,
    SHIFT_SWEEP
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP        = 3'd0,
    OP_SET        = 3'd1,
    OP_CLR        = 3'd2,
    OP_TOGGLE     = 3'd3,
    OP_CLEAR_ROW  = 3'd4,
    OP_FILL_ROW   = 3'd5,
    OP_CLEAR_ALL  = 3'd6,
    OP_SHIFT_DOWN = 3'd7
  } op_e;

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           cnt_q, cnt_d;
  logic [ROWS-1:0][COLS-1:0]  board_q, board_d;
  logic [ROWS-1:0][COLS-1:0]  data_q, data_d;
  logic                       pending_q, pending_d;
  logic                       err_q, err_d;
  logic                       busy_q, busy_d;
  logic                       rd_bit_q, rd_bit_d;

  op_e  op;
  logic accept;
  logic row_ok;
  logic col_ok;
  logic cmd_ok;
  logic rd_ok;

  assign op     = op_e'(cmd_op);
  assign accept = cmd_valid && cmd_ready;
  // Extra compare bit keeps the range checks meaningful for any grid size.
  assign row_ok = {1'b0, cmd_row} < CMP_W'(ROWS);
  assign col_ok = {1'b0, cmd_col} < CMP_W'(COLS);
  assign rd_ok  = ({1'b0, rd_row} < CMP_W'(ROWS)) && ({1'b0, rd_col} < CMP_W'(COLS));

  // Column is only checked for the single-cell ops.
  always_comb begin
    cmd_ok = row_ok;
    case (op)
      OP_SET, OP_CLR, OP_TOGGLE: cmd_ok = row_ok && col_ok;
      default:                   cmd_ok = row_ok;
    endcase
  end

  // Next-state, grid edit and commit logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    board_d   = board_q;
    data_d    = data_q;
    pending_d = pending_q;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        if (accept && (op != OP_NOP)) begin
          if (!cmd_ok) begin
            err_d = 1'b1;
          end else begin
            case (op)
              OP_SET:        board_d[cmd_row][cmd_col] = 1'b1;
              OP_CLR:        board_d[cmd_row][cmd_col] = 1'b0;
              OP_TOGGLE:     board_d[cmd_row][cmd_col] = ~board_q[cmd_row][cmd_col];
              OP_CLEAR_ROW:  board_d[cmd_row] = '0;
              OP_FILL_ROW:   board_d[cmd_row] = '1;
              OP_CLEAR_ALL: begin
                cnt_d   = IDX_W'(ROWS - 1);
                state_d = CLR_SWEEP;
              end
              OP_SHIFT_DOWN: begin
                cnt_d   = cmd_row;
                state_d = SHIFT_SWEEP;
              end
              default: ;
            endcase
          end
        end
      end

      // Clear one row per cycle from the top index down to row 0.
      CLR_SWEEP: begin
        board_d[cnt_q] = '0;
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - IDX_W'(1);
        end
      end

      // Move rows cnt-1 -> cnt downward, then empty row 0.
      SHIFT_SWEEP: begin
        if (cnt_q != '0) begin
          board_d[cnt_q] = board_q[cnt_q - IDX_W'(1)];
          cnt_d          = cnt_q - IDX_W'(1);
        end else begin
          board_d[0] = '0;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Commit the pre-edge grid in IDLE; a frame seen mid-sweep is deferred.
    if (state_q == IDLE) begin
      if (frame_start || pending_q) begin
        data_d    = board_q;
        pending_d = 1'b0;
      end
    end else if (frame_start) begin
      pending_d = 1'b1;
    end
  end

  assign busy_d   = (state_d != IDLE);
  assign rd_bit_d = rd_ok ? board_q[rd_row][rd_col] : 1'b0;

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      board_q   <= '0;
      data_q    <= '0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      rd_bit_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      board_q   <= board_d;
      data_q    <= data_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      rd_bit_q  <= rd_bit_d;
    end
  end

  // Full-row detect straight off the working grid.
  always_comb begin
    row_full = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      row_full[r] = &board_q[r];
    end
  end

  assign cmd_ready = !busy_q;
  assign busy      = busy_q;
  assign data      = data_q;
  assign err       = err_q;
  assign rd_bit    = rd_bit_q;

endmodule

// File: tb/tb_brick_board.sv
// tb_brick_board: directed self-checking bench for brick_board.
// Inputs change 1 time unit after the rising edge; outputs are sampled
// at that same point, after all registered updates have settled.
module tb_brick_board;

  localparam logic [2:0] OP_NOP        = 3'd0;
  localparam logic [2:0] OP_SET        = 3'd1;
  localparam logic [2:0] OP_CLR        = 3'd2;
  localparam logic [2:0] OP_TOGGLE     = 3'd3;
  localparam logic [2:0] OP_CLEAR_ROW  = 3'd4;
  localparam logic [2:0] OP_FILL_ROW   = 3'd5;
  localparam logic [2:0] OP_CLEAR_ALL  = 3'd6;
  localparam logic [2:0] OP_SHIFT_DOWN = 3'd7;

  logic         clock;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [3:0]   cmd_row;
  logic [3:0]   cmd_col;
  logic         frame_start;
  logic [191:0] data;
  logic [3:0]   rd_row;
  logic [3:0]   rd_col;
  logic         rd_bit;
  logic [11:0]  row_full;
  logic         busy;
  logic         err;

  int checks = 0;
  int errors = 0;

  brick_board #(.ROWS(12), .COLS(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_row     (cmd_row),
    .cmd_col     (cmd_col),
    .frame_start (frame_start),
    .data        (data),
    .rd_row      (rd_row),
    .rd_col      (rd_col),
    .rd_bit      (rd_bit),
    .row_full    (row_full),
    .busy        (busy),
    .err         (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = OP_NOP;
    cmd_row     = 4'd0;
    cmd_col     = 4'd0;
    frame_start = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  // One-cycle command; caller ensures cmd_ready is high.
  task automatic issue(input logic [2:0] op, input logic [3:0] r, input logic [3:0] c);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_row   = r;
    cmd_col   = c;
    step();
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  // Count cycles with busy high, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = OP_NOP;
    cmd_row     = 4'd0;
    cmd_col     = 4'd0;
    frame_start = 1'b0;
    rd_row      = 4'd0;
    rd_col      = 4'd0;
    step();
    step();
    checks++; if (data !== 192'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", data); end
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_busy: busy=%b ready=%b expected 0/1", busy, cmd_ready); end
    checks++; if (err !== 1'b0 || rd_bit !== 1'b0 || row_full !== 12'h000) begin errors++; $display("FAIL reset_misc: err=%b rd_bit=%b row_full=%h expected 0/0/000", err, rd_bit, row_full); end
    reset = 1'b1;
  endtask

  task automatic test_set_commit();
    logic [191:0] exp;
    do_reset();
    rd_row = 4'd3;
    rd_col = 4'd5;
    issue(OP_SET, 4'd3, 4'd5);
    checks++; if (rd_bit !== 1'b0) begin errors++; $display("FAIL set_rd_latency: got %b expected 0", rd_bit); end
    pulse_frame();
    exp = '0;
    exp[53] = 1'b1;
    checks++; if (data !== exp) begin errors++; $display("FAIL set_commit_data: got %h expected %h", data, exp); end
    checks++; if (rd_bit !== 1'b1) begin errors++; $display("FAIL set_rd_bit: got %b expected 1", rd_bit); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL set_err: got %b expected 0", err); end
  endtask

  task automatic test_deferred_commit();
    logic [191:0] exp;
    int changed;
    do_reset();
    issue(OP_SET, 4'd3, 4'd5);
    changed = 0;
    for (int i = 0; i < 1000; i++) begin
      if (data !== 192'd0) changed++;
      step();
    end
    checks++; if (changed !== 0 || data !== 192'd0) begin errors++; $display("FAIL no_frame_hold: %0d cycles nonzero, data %h expected 0", changed, data); end
    pulse_frame();
    exp = '0;
    exp[53] = 1'b1;
    checks++; if (data !== exp) begin errors++; $display("FAIL late_commit: got %h expected %h", data, exp); end
  endtask

  task automatic test_cell_ops();
    logic [191:0] exp;
    do_reset();
    issue(OP_SET, 4'd2, 4'd2);
    issue(OP_TOGGLE, 4'd2, 4'd3);
    issue(OP_TOGGLE, 4'd2, 4'd2);
    issue(OP_CLR, 4'd2, 4'd3);
    issue(OP_TOGGLE, 4'd2, 4'd15);
    issue(OP_NOP, 4'd15, 4'd0);
    issue(OP_FILL_ROW, 4'd5, 4'd0);
    checks++; if (row_full !== 12'h020) begin errors++; $display("FAIL fill_row5_full: got %h expected 020", row_full); end
    issue(OP_CLR, 4'd5, 4'd0);
    checks++; if (row_full !== 12'h000) begin errors++; $display("FAIL clr_row5_full: got %h expected 000", row_full); end
    issue(OP_FILL_ROW, 4'd9, 4'd0);
    issue(OP_CLEAR_ROW, 4'd9, 4'd0);
    pulse_frame();
    exp = '0;
    exp[47] = 1'b1;
    exp[95:80] = 16'hFFFE;
    checks++; if (data !== exp) begin errors++; $display("FAIL cell_ops_data: got %h expected %h", data, exp); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL nop_no_err: got %b expected 0", err); end
  endtask

  task automatic test_fill_shift();
    logic [191:0] exp;
    int n;
    do_reset();
    issue(OP_SET, 4'd3, 4'd5);
    issue(OP_SET, 4'd0, 4'd0);
    issue(OP_SET, 4'd7, 4'd9);
    issue(OP_FILL_ROW, 4'd11, 4'd0);
    checks++; if (row_full !== 12'h800) begin errors++; $display("FAIL fill11_full: got %h expected 800", row_full); end
    issue(OP_SHIFT_DOWN, 4'd11, 4'd0);
    wait_idle(n);
    checks++; if (n !== 12) begin errors++; $display("FAIL shift11_busy: got %0d cycles expected 12", n); end
    pulse_frame();
    exp = '0;
    exp[137] = 1'b1;
    exp[69] = 1'b1;
    exp[16] = 1'b1;
    checks++; if (data !== exp) begin errors++; $display("FAIL shift11_data: got %h expected %h", data, exp); end
    checks++; if (row_full !== 12'h000) begin errors++; $display("FAIL shift11_full: got %h expected 000", row_full); end
    issue(OP_SHIFT_DOWN, 4'd4, 4'd0);
    wait_idle(n);
    checks++; if (n !== 5) begin errors++; $display("FAIL shift4_busy: got %0d cycles expected 5", n); end
    issue(OP_SET, 4'd0, 4'd3);
    issue(OP_SHIFT_DOWN, 4'd0, 4'd0);
    wait_idle(n);
    checks++; if (n !== 1) begin errors++; $display("FAIL shift0_busy: got %0d cycles expected 1", n); end
    pulse_frame();
    exp = '0;
    exp[137] = 1'b1;
    exp[32] = 1'b1;
    checks++; if (data !== exp) begin errors++; $display("FAIL shift4_0_data: got %h expected %h", data, exp); end
  endtask

  task automatic test_clear_all();
    logic [191:0] exp;
    int n;
    int not_ready;
    int stale;
    do_reset();
    for (int r = 0; r < 12; r++) issue(OP_FILL_ROW, 4'(r), 4'd0);
    checks++; if (row_full !== 12'hFFF) begin errors++; $display("FAIL fill_all_full: got %h expected fff", row_full); end
    pulse_frame();
    exp = '1;
    checks++; if (data !== exp) begin errors++; $display("FAIL fill_all_data: got %h expected %h", data, exp); end
    rd_row = 4'd11;
    rd_col = 4'd15;
    step();
    checks++; if (rd_bit !== 1'b1) begin errors++; $display("FAIL rd_11_15: got %b expected 1", rd_bit); end
    rd_row = 4'd12;
    rd_col = 4'd0;
    step();
    checks++; if (rd_bit !== 1'b0) begin errors++; $display("FAIL rd_out_of_range: got %b expected 0", rd_bit); end
    issue(OP_CLEAR_ALL, 4'd0, 4'd0);
    n = 0;
    not_ready = 0;
    stale = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (cmd_ready !== 1'b1) not_ready++;
      if (data !== exp) stale++;
      frame_start = (n == 5);
      step();
    end
    frame_start = 1'b0;
    checks++; if (n !== 12 || not_ready !== 12) begin errors++; $display("FAIL clear_all_busy: busy %0d not_ready %0d expected 12/12", n, not_ready); end
    checks++; if (stale !== 0 || data !== exp) begin errors++; $display("FAIL clear_all_hold: %0d changed cycles, data %h expected all ones", stale, data); end
    step();
    checks++; if (data !== 192'd0) begin errors++; $display("FAIL clear_all_commit: got %h expected 0", data); end
    checks++; if (cmd_ready !== 1'b1 || row_full !== 12'h000) begin errors++; $display("FAIL clear_all_end: ready=%b row_full=%h expected 1/000", cmd_ready, row_full); end
  endtask

  task automatic test_errors();
    logic [191:0] exp;
    do_reset();
    issue(OP_SET, 4'd12, 4'd0);
    checks++; if (err !== 1'b1 || cmd_ready !== 1'b1) begin errors++; $display("FAIL err_set_row12: err=%b ready=%b expected 1/1", err, cmd_ready); end
    issue(OP_TOGGLE, 4'd13, 4'd15);
    issue(OP_FILL_ROW, 4'd12, 4'd0);
    checks++; if (row_full !== 12'h000) begin errors++; $display("FAIL err_fill_row12: row_full %h expected 000", row_full); end
    issue(OP_CLEAR_ALL, 4'd14, 4'd0);
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL err_no_sweep: busy=%b ready=%b expected 0/1", busy, cmd_ready); end
    pulse_frame();
    checks++; if (data !== 192'd0) begin errors++; $display("FAIL err_grid_unchanged: got %h expected 0", data); end
    issue(OP_SET, 4'd1, 4'd1);
    pulse_frame();
    exp = '0;
    exp[17] = 1'b1;
    checks++; if (data !== exp || err !== 1'b1) begin errors++; $display("FAIL err_sticky: data %h err %b expected %h / 1", data, err, exp); end
  endtask

  task automatic test_same_edge();
    logic [191:0] exp;
    do_reset();
    issue(OP_SET, 4'd6, 4'd6);
    pulse_frame();
    cmd_valid   = 1'b1;
    cmd_op      = OP_SET;
    cmd_row     = 4'd6;
    cmd_col     = 4'd7;
    frame_start = 1'b1;
    step();
    cmd_valid   = 1'b0;
    cmd_op      = OP_NOP;
    frame_start = 1'b0;
    exp = '0;
    exp[102] = 1'b1;
    checks++; if (data !== exp) begin errors++; $display("FAIL same_edge_old: got %h expected %h", data, exp); end
    pulse_frame();
    exp[103] = 1'b1;
    checks++; if (data !== exp) begin errors++; $display("FAIL same_edge_next: got %h expected %h", data, exp); end
  endtask

  task automatic test_reset_mid_sweep();
    do_reset();
    issue(OP_FILL_ROW, 4'd2, 4'd0);
    issue(OP_SET, 4'd12, 4'd0);
    pulse_frame();
    issue(OP_CLEAR_ALL, 4'd0, 4'd0);
    step();
    step();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_busy: busy=%b ready=%b expected 0/1", busy, cmd_ready); end
    checks++; if (data !== 192'd0 || err !== 1'b0) begin errors++; $display("FAIL mid_reset_clear: data %h err %b expected 0/0", data, err); end
    step();
    checks++; if (busy !== 1'b0 || row_full !== 12'h000) begin errors++; $display("FAIL mid_reset_after: busy=%b row_full=%h expected 0/000", busy, row_full); end
  endtask

  initial begin
    test_reset();
    test_set_commit();
    test_deferred_commit();
    test_cell_ops();
    test_fill_shift();
    test_clear_all();
    test_errors();
    test_same_edge();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
